ps2_dir_keystroke_tx: RTL and testbench

//  Device-side PS/2 keystroke transmitter, the counterpart of the keyboard direction decoder.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_frame_tx.sv | 86 ++++++++
 rtl/ps2_dir_keystroke_tx.sv | 129 ++++++++++++
 tb/tb_ps2_dir_keystroke_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keystroke transmitter: scan codes, one-hot
// direction values, FSM encodings and the direction-to-scan-code map.
package ps2_pkg;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_WAIT_BUS, SEQ_SEND} seq_state_t;
  typedef enum logic [1:0] {FR_IDLE, FR_BIT_HI, FR_BIT_LO} frame_state_t;
  typedef enum logic [1:0] {PH_MAKE, PH_BREAK_PFX, PH_BREAK_CODE} seq_phase_t;

  // {valid, code}; valid is 0 for anything that is not a single known direction
  function automatic logic [8:0] f_dir_code(input logic [3:0] dir);
    case (dir)
      DIR_UP:    f_dir_code = {1'b1, SC_W};
      DIR_DOWN:  f_dir_code = {1'b1, SC_S};
      DIR_LEFT:  f_dir_code = {1'b1, SC_A};
      DIR_RIGHT: f_dir_code = {1'b1, SC_D};
      default:   f_dir_code = 9'h000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Single-byte PS/2 device-to-host serialiser: start, 8 data bits LSB first,
// odd parity (optionally inverted), stop. Aborts on host inhibit before the stop bit.
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       par_inv,
  input  logic       bus_clk_sync,
  output logic       ps2_clk_o,
  output logic       ps2_dat_o,
  output logic       done,
  output logic       aborted
);
  localparam int               DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  frame_state_t          r_state, w_next;
  logic [DIV_W-1:0]      r_div;
  logic [3:0]            r_bit;
  logic [FRAME_BITS-2:0] r_frame;
  logic                  r_dat;
  logic                  w_div_end, w_inhibit;

  assign w_div_end = (r_div == DIV_LAST);
  // Host inhibit only matters before the stop bit; a stop bit always completes.
  assign w_inhibit = !bus_clk_sync && (r_bit != LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FR_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FR_IDLE:   if (start) w_next = FR_BIT_HI;
      FR_BIT_HI: if (w_div_end) w_next = w_inhibit ? FR_IDLE : FR_BIT_LO;
      FR_BIT_LO: if (w_div_end) w_next = (r_bit == LAST_BIT) ? FR_IDLE : FR_BIT_HI;
      default:   w_next = FR_IDLE;
    endcase
  end

  always_comb begin
    ps2_clk_o = (r_state != FR_BIT_LO);
    ps2_dat_o = r_dat;
    done      = (r_state == FR_BIT_LO) && w_div_end && (r_bit == LAST_BIT);
    aborted   = (r_state == FR_BIT_HI) && w_div_end && w_inhibit;
  end

  // r_frame holds bits 1..10 of the frame; the start bit is driven directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_frame <= '1;
      r_dat   <= 1'b1;
    end else begin
      if (r_state != w_next)      r_div <= '0;
      else if (r_state != FR_IDLE) r_div <= r_div + 1'b1;
      case (r_state)
        FR_IDLE: if (start) begin
          r_frame <= {1'b1, (~^tx_byte) ^ par_inv, tx_byte};
          r_bit   <= '0;
          r_dat   <= 1'b0;
        end
        FR_BIT_HI: if (w_div_end && w_inhibit) r_dat <= 1'b1;
        FR_BIT_LO: if (w_div_end) begin
          if (r_bit == LAST_BIT) begin
            r_dat <= 1'b1;
          end else begin
            r_dat <= r_frame[r_bit];
            r_bit <= r_bit + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_dir_keystroke_tx.sv
// Direction-to-WASD PS/2 keystroke sequencer: make code, hold, F0, code.
// Define PS2_ERR_INJECT_EN to add err_inject (inverts make-frame parity).
module ps2_dir_keystroke_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV  = 4000,
  parameter int GAP_CYC  = 8000,
  parameter int HOLD_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dir_in,
  input  logic       dir_valid,
  output logic       dir_ready,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_o,
  output logic       ps2_dat_o,
  output logic       busy,
  output logic       dir_err
`ifdef PS2_ERR_INJECT_EN
  ,
  input  logic       err_inject
`endif
);
  localparam int               CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int               CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_T   = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] HOLD_T  = CNT_W'(HOLD_CYC);

  seq_state_t       r_state, w_next;
  seq_phase_t       r_phase;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_code;
  logic             r_par_inv, r_hold, r_dir_err;
  logic [8:0]       w_map;
  logic [7:0]       w_tx_byte;
  logic [CNT_W-1:0] w_target;
  logic             w_accept, w_dir_ok, w_inject, w_bus_idle, w_cnt_hit;
  logic             w_start, w_done, w_aborted, w_par_inv;

`ifdef PS2_ERR_INJECT_EN
  assign w_inject = err_inject;
`else
  assign w_inject = 1'b0;
`endif

  // Handshake: a request transfers on any cycle with dir_valid && dir_ready;
  // dir_ready is high only in IDLE, so requests arriving while busy just wait.
  assign w_map      = f_dir_code(dir_in);
  assign w_dir_ok   = w_map[8];
  assign w_accept   = dir_valid && dir_ready;
  assign w_bus_idle = r_sync[1];
  assign w_target   = r_hold ? HOLD_T : GAP_T;
  assign w_cnt_hit  = w_bus_idle && (r_cnt == w_target);
  assign dir_err    = r_dir_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SEQ_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      SEQ_IDLE:     if (w_accept && w_dir_ok) w_next = SEQ_WAIT_BUS;
      SEQ_WAIT_BUS: if (w_cnt_hit) w_next = SEQ_SEND;
      SEQ_SEND: begin
        if (w_aborted)  w_next = SEQ_WAIT_BUS;
        else if (w_done) w_next = (r_phase == PH_BREAK_CODE) ? SEQ_IDLE : SEQ_WAIT_BUS;
      end
      default: w_next = SEQ_IDLE;
    endcase
  end

  always_comb begin
    dir_ready = (r_state == SEQ_IDLE);
    busy      = (r_state != SEQ_IDLE);
    w_start   = (r_state == SEQ_WAIT_BUS) && w_cnt_hit;
    w_tx_byte = (r_phase == PH_BREAK_PFX) ? SC_BREAK : r_code;
    w_par_inv = r_par_inv && (r_phase == PH_MAKE);
  end

  // r_hold selects the long idle wait only for the first F0 attempt after a make frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_cnt     <= '0;
      r_code    <= '0;
      r_phase   <= PH_MAKE;
      r_par_inv <= 1'b0;
      r_hold    <= 1'b0;
      r_dir_err <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], ps2_clk_i};
      r_dir_err <= w_accept && !w_dir_ok;
      if (r_state != SEQ_WAIT_BUS || !w_bus_idle || w_cnt_hit) r_cnt <= '0;
      else                                                     r_cnt <= r_cnt + 1'b1;
      if (w_accept && w_dir_ok) begin
        r_code    <= w_map[7:0];
        r_phase   <= PH_MAKE;
        r_par_inv <= w_inject;
      end
      if (w_start) r_hold <= 1'b0;
      if (r_state == SEQ_SEND && w_done) begin
        if (r_phase == PH_MAKE) begin
          r_phase <= PH_BREAK_PFX;
          r_hold  <= 1'b1;
        end else if (r_phase == PH_BREAK_PFX) begin
          r_phase <= PH_BREAK_CODE;
        end
      end
    end
  end

  ps2_frame_tx #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk          (clk),
    .rst          (rst),
    .start        (w_start),
    .tx_byte      (w_tx_byte),
    .par_inv      (w_par_inv),
    .bus_clk_sync (w_bus_idle),
    .ps2_clk_o    (ps2_clk_o),
    .ps2_dat_o    (ps2_dat_o),
    .done         (w_done),
    .aborted      (w_aborted)
  );

endmodule

// File: tb/tb_ps2_dir_keystroke_tx.sv
// Bench for ps2_dir_keystroke_tx: a host-side frame decoder plus a request-level
// model (each accepted direction expects CODE, F0, CODE) checked every cycle.
module tb_ps2_dir_keystroke_tx;
  localparam int CLK_DIV  = 4;
  localparam int GAP_CYC  = 8;
  localparam int HOLD_CYC = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dir_in;
  logic       dir_valid, dir_ready;
  logic       ps2_clk_i, ps2_clk_o, ps2_dat_o;
  logic       busy, dir_err;
  logic       host_inhibit;

  assign ps2_clk_i = host_inhibit ? 1'b0 : ps2_clk_o;

  always #5 clk = ~clk;

  ps2_dir_keystroke_tx #(
    .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dir_in    (dir_in),
    .dir_valid (dir_valid),
    .dir_ready (dir_ready),
    .ps2_clk_i (ps2_clk_i),
    .ps2_clk_o (ps2_clk_o),
    .ps2_dat_o (ps2_dat_o),
    .busy      (busy),
`ifdef PS2_ERR_INJECT_EN
    .err_inject(1'b0),
`endif
    .dir_err   (dir_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] code_of(input logic [3:0] d);
    case (d)
      4'b1000: return 8'h1D;
      4'b0100: return 8'h1B;
      4'b0010: return 8'h1C;
      default: return 8'h23;
    endcase
  endfunction

  // Model and host-side monitor state
  logic [7:0]  exp_q[$];
  int          acc_cyc[$];
  int          n_accepts = 0;
  logic        exp_err = 1'b0;
  logic [10:0] rx_bits_q[$];
  int          rx_start_q[$];
  int          rx_end_q[$];
  int          n_rx = 0;
  int          n_aborts = 0;
  int          bitcnt = 0;
  int          hi_run = 0;
  int          lo_run = 0;
  int          fall0 = 0;
  logic        prev_clk = 1'b1;
  logic [10:0] sh = '0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready", dir_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_err", dir_err, 0);
      check("rst_lines", {ps2_clk_o, ps2_dat_o}, 2'b11);
      exp_q.delete();
      exp_err  = 1'b0;
      bitcnt   = 0;
      hi_run   = 0;
      lo_run   = 0;
      prev_clk = 1'b1;
    end else begin
      check("dir_err", dir_err, exp_err);
      check("ready_vs_busy", dir_ready, !busy);
      if (!busy) check("idle_lines", {ps2_clk_o, ps2_dat_o}, 2'b11);
      exp_err = 1'b0;
      if (dir_valid && dir_ready) begin
        if ($countones(dir_in) == 1) begin
          exp_q.push_back(code_of(dir_in));
          exp_q.push_back(8'hF0);
          exp_q.push_back(code_of(dir_in));
          acc_cyc.push_back(cyc);
          n_accepts++;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (ps2_clk_o) begin
        if (!prev_clk) begin
          check("low_width", lo_run, CLK_DIV);
          hi_run = 0;
          if (bitcnt == 11) begin
            check("start_bit", sh[0], 0);
            check("stop_bit", sh[10], 1);
            check("odd_parity", ^sh[9:1], 1);
            check("frame_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("frame_byte", sh[8:1], exp_q.pop_front());
            rx_bits_q.push_back(sh);
            rx_start_q.push_back(fall0);
            rx_end_q.push_back(cyc);
            n_rx++;
            bitcnt = 0;
          end
        end
        hi_run++;
        if (bitcnt > 0 && bitcnt < 11 && hi_run > CLK_DIV) begin
          n_aborts++;
          bitcnt = 0;
        end
      end else begin
        if (prev_clk) begin
          if (bitcnt > 0) check("high_width", hi_run, CLK_DIV);
          else            fall0 = cyc;
          lo_run = 0;
          if (bitcnt < 11) sh[bitcnt] = ps2_dat_o;
          bitcnt++;
        end
        lo_run++;
      end
      prev_clk = ps2_clk_o;
    end
  end

  task automatic send_dir(input logic [3:0] d);
    @(posedge clk); #1;
    dir_in    = d;
    dir_valid = 1'b1;
    @(posedge clk); #1;
    dir_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int k = 0;
    while (n_rx < n && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_rx", n_rx >= n, 1);
  endtask

  task automatic wait_bitcnt(input int b);
    int k = 0;
    while (bitcnt != b && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_bitcnt", bitcnt, b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n_acc0, ab0, rel, n_err_hi, n_rdy_lo, n_clk_lo, n_busy;
    logic [10:0] bits;
    rst = 1'b1; dir_in = 4'b0000; dir_valid = 1'b0; host_inhibit = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_ready", dir_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_lines", {ps2_clk_o, ps2_dat_o}, 2'b11);

    // T1: UP -> 1D, F0, 1D with exact latencies
    base = n_rx; n_acc0 = n_accepts;
    send_dir(4'b1000);
    wait_rx(base + 3);
    if (n_rx >= base + 3) begin
      bits = rx_bits_q[base];
      check("t1_bits_1D", bits, 11'b11000111010);
      check("t1_first_fall", rx_start_q[base] - acc_cyc[n_acc0], 2 + GAP_CYC + CLK_DIV);
      check("t1_hold_gap", rx_start_q[base+1] - rx_end_q[base], HOLD_CYC + CLK_DIV + 3);
      check("t1_gap", rx_start_q[base+2] - rx_end_q[base+1], GAP_CYC + CLK_DIV + 3);
    end
    repeat (2) @(posedge clk); #1;
    check("t1_ready_after", dir_ready, 1);

    // T2: RIGHT -> 23 (par 0), F0 (par 1), 23
    base = n_rx;
    send_dir(4'b0001);
    wait_rx(base + 3);
    if (n_rx >= base + 3) begin
      bits = rx_bits_q[base];
      check("t2_bits_23", bits, 11'b10001000110);
      bits = rx_bits_q[base+1];
      check("t2_bits_F0", bits, 11'b11111100000);
      check("t2_hold_min", (rx_start_q[base+1] - rx_end_q[base]) >= HOLD_CYC, 1);
    end

    // T3: non-one-hot request
    base = n_rx;
    n_err_hi = 0; n_rdy_lo = 0; n_clk_lo = 0; n_busy = 0;
    send_dir(4'b0110);
    for (int i = 0; i < 8; i++) begin
      n_err_hi += int'(dir_err);
      n_rdy_lo += int'(!dir_ready);
      n_clk_lo += int'(!ps2_clk_o);
      n_busy   += int'(busy);
      @(posedge clk); #1;
    end
    check("t3_err_pulses", n_err_hi, 1);
    check("t3_ready_low_max1", n_rdy_lo <= 1, 1);
    check("t3_clk_low", n_clk_lo, 0);
    check("t3_busy", n_busy, 0);

    // T4: host inhibit during bit 4 of F0
    base = n_rx;
    send_dir(4'b0100);
    wait_rx(base + 1);
    wait_bitcnt(4);
    ab0 = n_aborts;
    host_inhibit = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("t4_lines_high", {ps2_clk_o, ps2_dat_o}, 2'b11);
    rel = cyc;
    host_inhibit = 1'b0;
    wait_rx(base + 3);
    check("t4_aborts", n_aborts - ab0, 1);
    if (n_rx >= base + 3)
      check("t4_resend_gap", rx_start_q[base+1] - rel, GAP_CYC + CLK_DIV + 3);

    // T5: dir_valid held through the whole sequence
    base = n_rx; n_acc0 = n_accepts;
    @(posedge clk); #1;
    dir_in = 4'b0010; dir_valid = 1'b1;
    wait_rx(base + 3);
    dir_valid = 1'b0;
    check("t5_accepts", n_accepts - n_acc0, 2);
    if (n_accepts >= n_acc0 + 2 && n_rx >= base + 3)
      check("t5_second_accept", acc_cyc[n_acc0+1], rx_end_q[base+2]);
    wait_rx(base + 6);

    // T6: async reset in the middle of a make frame
    base = n_rx; ab0 = n_aborts;
    send_dir(4'b0001);
    wait_bitcnt(5);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_lines_now", {ps2_clk_o, ps2_dat_o}, 2'b11);
    check("t6_ready_now", dir_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_ready_after", dir_ready, 1);
    repeat (150) @(posedge clk);
    #1;
    check("t6_no_frames", n_rx - base, 0);
    check("t6_busy", busy, 0);

    // Recovery after reset: a fresh request sends only its own bytes
    base = n_rx;
    send_dir(4'b1000);
    wait_rx(base + 3);
    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_aborts", n_aborts - ab0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
